// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the arbiter and the SRAM.
// The arbiter uses the slave modport; the requesters and memory use master.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [11:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_cen;
  logic        mem_wen;
  logic [11:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_cen, mem_wen, mem_addr, mem_din
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_cen, mem_wen, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester single-port SRAM arbiter: data-first priority with an instruction
// starvation guard, and a tag pipeline that routes read returns to their source.
module mem_port_arbiter #(
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic {
    PRI_D = 1'b0,
    PRI_I = 1'b1
  } pri_t;

  pri_t              state_q, state_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic [RD_LAT-1:0] tag_vld_q;
  logic [RD_LAT-1:0] tag_src_q;
  logic [31:0]       i_rdata_q, d_rdata_q;

  logic        i_gnt, d_gnt;
  logic        rd_push, src_push;
  logic        i_rv, d_rv;
  logic        mem_cen, mem_wen;
  logic [11:0] mem_addr;
  logic [31:0] mem_din;

  // Grants are purely combinational; reset masks every request.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (bus.i_req && (!bus.d_req || state_q == PRI_I)) begin
        i_gnt = 1'b1;
      end else if (bus.d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = '0;
    if (bus.i_req && !i_gnt) begin
      starve_d = (starve_q == SMAX) ? starve_q : starve_q + 1'b1;
    end
  end

  // Switching on the counter's next value lets the forced grant land on the
  // cycle right after the STARVE_MAX-th denial.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PRI_D: if (starve_d == SMAX) state_d = PRI_I;
      PRI_I: if (i_gnt)            state_d = PRI_D;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PRI_D;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    mem_cen  = 1'b1;
    mem_wen  = 1'b1;
    mem_addr = '0;
    mem_din  = '0;
    if (i_gnt) begin
      mem_cen  = 1'b0;
      mem_addr = bus.i_addr;
    end else if (d_gnt) begin
      mem_cen  = 1'b0;
      mem_wen  = ~bus.d_we;
      mem_addr = bus.d_addr;
      mem_din  = bus.d_wdata;
    end
  end

  assign rd_push  = i_gnt | (d_gnt & ~bus.d_we);
  assign src_push = i_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      tag_src_q <= '0;
    end else begin
      tag_vld_q[0] <= rd_push;
      tag_src_q[0] <= src_push;
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_src_q[k] <= tag_src_q[k-1];
      end
    end
  end

  assign i_rv = !rst && tag_vld_q[RD_LAT-1] &&  tag_src_q[RD_LAT-1];
  assign d_rv = !rst && tag_vld_q[RD_LAT-1] && !tag_src_q[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_rv) i_rdata_q <= bus.mem_dout;
      if (d_rv) d_rdata_q <= bus.mem_dout;
    end
  end

  assign bus.i_gnt    = i_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.i_rvalid = i_rv;
  assign bus.d_rvalid = d_rv;
  assign bus.i_rdata  = i_rv ? bus.mem_dout : i_rdata_q;
  assign bus.d_rdata  = d_rv ? bus.mem_dout : d_rdata_q;
  assign bus.mem_cen  = mem_cen;
  assign bus.mem_wen  = mem_wen;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_din  = mem_din;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: a behavioural SRAM drives mem_dout, and a transaction-level
// model (priority flag, denial count, return queue) predicts every cycle.
module tb_mem_port_arbiter;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] init_word(input logic [11:0] a);
    if (a == 12'h004) return 32'hDEADBEEF;
    return ({20'h0, a} * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Behavioural SRAM with registered Q plus one delay stage.
  logic [31:0] sram [0:4095];
  logic [31:0] pipe0, pipe1;
  logic        sram_init = 1'b0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int a = 0; a < 4096; a++) sram[a] <= init_word(12'(a));
      sram_init <= 1'b1;
    end else if (!bus.mem_cen && !bus.mem_wen) begin
      sram[bus.mem_addr] <= bus.mem_din;
    end
    if (!bus.mem_cen && bus.mem_wen) pipe0 <= sram[bus.mem_addr];
    else                             pipe0 <= 32'hBAD0_BAD0;
    pipe1 <= pipe0;
  end
  assign bus.mem_dout = pipe1;

  // Reference model state.
  typedef struct { int due; bit src_i; logic [31:0] data; } ret_t;
  ret_t        m_q[$];
  bit          m_pri_i;
  int          m_denied;
  int          m_cyc;
  logic [31:0] m_last_i, m_last_d;
  logic [31:0] ref_mem [0:4095];

  logic        e_i_gnt, e_d_gnt, e_i_rv, e_d_rv, e_cen, e_wen;
  logic [11:0] e_addr;
  logic [31:0] e_din, e_i_rd, e_d_rd;

  function automatic void model_eval();
    e_i_gnt = 1'b0; e_d_gnt = 1'b0; e_i_rv = 1'b0; e_d_rv = 1'b0;
    e_cen = 1'b1; e_wen = 1'b1; e_addr = '0; e_din = '0;
    if (!rst) begin
      if (bus.i_req && bus.d_req) begin
        e_i_gnt = m_pri_i;
        e_d_gnt = !m_pri_i;
      end else begin
        e_i_gnt = bus.i_req;
        e_d_gnt = bus.d_req;
      end
      if (e_i_gnt) begin
        e_cen = 1'b0; e_addr = bus.i_addr;
      end
      if (e_d_gnt) begin
        e_cen = 1'b0; e_wen = !bus.d_we; e_addr = bus.d_addr; e_din = bus.d_wdata;
      end
      if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
        if (m_q[0].src_i) e_i_rv = 1'b1;
        else              e_d_rv = 1'b1;
      end
    end
    e_i_rd = e_i_rv ? m_q[0].data : m_last_i;
    e_d_rd = e_d_rv ? m_q[0].data : m_last_d;
  endfunction

  function automatic void model_update();
    ret_t r;
    if (rst) begin
      m_pri_i = 1'b0; m_denied = 0; m_q.delete(); m_last_i = '0; m_last_d = '0;
    end else begin
      if (e_i_rv) m_last_i = m_q[0].data;
      if (e_d_rv) m_last_d = m_q[0].data;
      if (e_i_rv || e_d_rv) void'(m_q.pop_front());
      if (e_d_gnt && bus.d_we) begin
        ref_mem[bus.d_addr] = bus.d_wdata;
      end else if (e_d_gnt) begin
        r.due = m_cyc + RD_LAT; r.src_i = 1'b0; r.data = ref_mem[bus.d_addr];
        m_q.push_back(r);
      end
      if (e_i_gnt) begin
        r.due = m_cyc + RD_LAT; r.src_i = 1'b1; r.data = ref_mem[bus.i_addr];
        m_q.push_back(r);
      end
      if (m_pri_i && e_i_gnt) m_pri_i = 1'b0;
      if (bus.i_req && !e_i_gnt) m_denied = (m_denied < STARVE_MAX) ? m_denied + 1 : STARVE_MAX;
      else                       m_denied = 0;
      if (!m_pri_i && m_denied == STARVE_MAX) m_pri_i = 1'b1;
    end
    m_cyc++;
  endfunction

  task automatic drive(input bit ir, input logic [11:0] ia, input bit dr, input bit dw,
                       input logic [11:0] da, input logic [31:0] dd);
    bus.i_req = ir; bus.i_addr = ia; bus.d_req = dr; bus.d_we = dw;
    bus.d_addr = da; bus.d_wdata = dd;
  endtask

  task automatic step_pre();
    @(negedge clk);
    model_eval();
  endtask

  task automatic step_post();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 12'h001, 1, 0, 12'h002, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step_pre();
      n_checks++;
      if ({bus.i_gnt, bus.d_gnt, bus.mem_cen, bus.mem_wen, bus.i_rvalid, bus.d_rvalid} !== 6'b001100) begin
        n_fail++;
        $display("FAIL reset_ctl: got gnt=%b%b cen=%b wen=%b rv=%b%b want gnt=00 cen=1 wen=1 rv=00",
                 bus.i_gnt, bus.d_gnt, bus.mem_cen, bus.mem_wen, bus.i_rvalid, bus.d_rvalid);
      end
      n_checks++;
      if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin
        n_fail++;
        $display("FAIL reset_rdata: got i=%h d=%h want 0", bus.i_rdata, bus.d_rdata);
      end
      step_post();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step_pre(); step_post();
  endtask

  task automatic test_lone_ifetch();
    drive(1, 12'h004, 0, 0, 0, 0);
    step_pre();
    n_checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.mem_cen, bus.mem_wen, bus.mem_addr} !== {4'b1001, 12'h004}) begin
      n_fail++;
      $display("FAIL lone_grant: got gnt=%b%b cen=%b wen=%b addr=%h want gnt=10 cen=0 wen=1 addr=004",
               bus.i_gnt, bus.d_gnt, bus.mem_cen, bus.mem_wen, bus.mem_addr);
    end
    step_post();
    drive(0, 0, 0, 0, 0, 0);
    step_pre();
    n_checks++;
    if (bus.i_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL lone_rv_early: got %b want 0", bus.i_rvalid);
    end
    step_post();
    step_pre();
    n_checks++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL lone_return: got rv=%b%b i_rdata=%h want rv=10 i_rdata=deadbeef",
               bus.i_rvalid, bus.d_rvalid, bus.i_rdata);
    end
    step_post();
    step_pre();
    n_checks++;
    if ({bus.i_rvalid, bus.i_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL lone_hold: got rv=%b i_rdata=%h want rv=0 i_rdata=deadbeef", bus.i_rvalid, bus.i_rdata);
    end
    step_post();
  endtask

  task automatic test_write_read();
    drive(0, 0, 1, 1, 12'h010, 32'h12345678);
    step_pre();
    n_checks++;
    if ({bus.i_gnt, bus.d_gnt, bus.mem_cen, bus.mem_wen, bus.mem_addr, bus.mem_din}
        !== {4'b0100, 12'h010, 32'h12345678}) begin
      n_fail++;
      $display("FAIL wr_issue: got gnt=%b%b cen=%b wen=%b addr=%h din=%h want gnt=01 cen=0 wen=0 addr=010 din=12345678",
               bus.i_gnt, bus.d_gnt, bus.mem_cen, bus.mem_wen, bus.mem_addr, bus.mem_din);
    end
    step_post();
    drive(0, 0, 1, 0, 12'h010, 32'h0);
    step_pre();
    n_checks++;
    if ({bus.d_gnt, bus.mem_cen, bus.mem_wen, bus.mem_addr} !== {3'b101, 12'h010}) begin
      n_fail++;
      $display("FAIL rd_issue: got d_gnt=%b cen=%b wen=%b addr=%h want d_gnt=1 cen=0 wen=1 addr=010",
               bus.d_gnt, bus.mem_cen, bus.mem_wen, bus.mem_addr);
    end
    step_post();
    drive(0, 0, 0, 0, 0, 0);
    step_pre();
    n_checks++;
    if (bus.d_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL wr_no_rvalid: got %b want 0", bus.d_rvalid);
    end
    step_post();
    step_pre();
    n_checks++;
    if ({bus.d_rvalid, bus.i_rvalid, bus.d_rdata} !== {2'b10, 32'h12345678}) begin
      n_fail++;
      $display("FAIL raw_return: got rv_d=%b rv_i=%b d_rdata=%h want 1 0 12345678",
               bus.d_rvalid, bus.i_rvalid, bus.d_rdata);
    end
    step_post();
    step_pre();
    n_checks++;
    if (bus.d_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL raw_single: got %b want 0", bus.d_rvalid);
    end
    step_post();
  endtask

  task automatic test_starve();
    logic [11:0] ia, da;
    ia = 12'($urandom); da = 12'($urandom);
    rst = 1'b1;
    drive(1, ia, 1, 0, da, 0);
    step_pre(); step_post();
    rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      if (k < 15) drive(1, ia, 1, 0, da, 0);
      else        drive(0, 0, 0, 0, 0, 0);
      step_pre();
      if (k < 15) begin
        n_checks++;
        if ({bus.i_gnt, bus.d_gnt} !== ((k % 5 == 4) ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL starve_gnt k=%0d: got %b%b want %b", k, bus.i_gnt, bus.d_gnt,
                   (k % 5 == 4) ? 2'b10 : 2'b01);
        end
      end
      n_checks++;
      if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata} !== {e_i_rv, e_d_rv, e_i_rd, e_d_rd}) begin
        n_fail++;
        $display("FAIL starve_ret k=%0d: got rv=%b%b i=%h d=%h want rv=%b%b i=%h d=%h", k,
                 bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata, e_i_rv, e_d_rv, e_i_rd, e_d_rd);
      end
      if (bus.i_gnt) ia = 12'($urandom);
      if (bus.d_gnt) da = 12'($urandom);
      step_post();
    end
  endtask

  task automatic test_alternating();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (k >= 10)         drive(0, 0, 0, 0, 0, 0);
      else if (k % 2 == 0) drive(1, 12'($urandom), 0, 0, 0, 0);
      else                 drive(0, 0, 1, 0, 12'($urandom), 0);
      step_pre();
      n_checks++;
      if ({bus.i_gnt, bus.d_gnt} !== ((k >= 10) ? 2'b00 : (k % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL alt_gnt k=%0d: got %b%b", k, bus.i_gnt, bus.d_gnt);
      end
      n_checks++;
      if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata} !== {e_i_rv, e_d_rv, e_i_rd, e_d_rd}) begin
        n_fail++;
        $display("FAIL alt_ret k=%0d: got rv=%b%b i=%h d=%h want rv=%b%b i=%h d=%h", k,
                 bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata, e_i_rv, e_d_rv, e_i_rd, e_d_rd);
      end
      pulses += int'(bus.i_rvalid === 1'b1) + int'(bus.d_rvalid === 1'b1);
      step_post();
    end
    n_checks++;
    if (pulses != 10) begin
      n_fail++; $display("FAIL alt_pulses: got %0d want 10", pulses);
    end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 10; k++) begin
      rst = (k == 5);
      if (k < 4 || k == 5 || k == 6) drive(1, 12'h020, 1, 0, 12'h030, 0);
      else if (k == 4)                drive(0, 0, 1, 0, 12'h031, 0);
      else                            drive(0, 0, 0, 0, 0, 0);
      step_pre();
      if (k <= 4 || k == 6) begin
        n_checks++;
        if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin
          n_fail++; $display("FAIL mrst_gnt k=%0d: got %b%b want 01", k, bus.i_gnt, bus.d_gnt);
        end
      end
      if (k == 5) begin
        n_checks++;
        if ({bus.i_gnt, bus.d_gnt, bus.mem_cen, bus.mem_wen, bus.i_rvalid, bus.d_rvalid} !== 6'b001100) begin
          n_fail++;
          $display("FAIL mrst_hold: got gnt=%b%b cen=%b wen=%b rv=%b%b want 00 1 1 00",
                   bus.i_gnt, bus.d_gnt, bus.mem_cen, bus.mem_wen, bus.i_rvalid, bus.d_rvalid);
        end
      end
      if (k == 6 || k == 7) begin
        n_checks++;
        if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00) begin
          n_fail++; $display("FAIL mrst_stale k=%0d: got rv=%b%b want 00", k, bus.i_rvalid, bus.d_rvalid);
        end
      end
      n_checks++;
      if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata} !== {e_i_rv, e_d_rv, e_i_rd, e_d_rd}) begin
        n_fail++;
        $display("FAIL mrst_ret k=%0d: got rv=%b%b i=%h d=%h want rv=%b%b i=%h d=%h", k,
                 bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata, e_i_rv, e_d_rv, e_i_rd, e_d_rd);
      end
      step_post();
    end
    rst = 1'b0;
  endtask

  task automatic test_starve_drop();
    logic [8:0] ireq_pat, ignt_pat;
    ireq_pat = 9'b111110111;
    ignt_pat = 9'b100000000;
    for (int k = 0; k < 9; k++) begin
      drive(ireq_pat[k], 12'h040, 1, 0, 12'h050 + 12'(k), 0);
      step_pre();
      n_checks++;
      if ({bus.i_gnt, bus.d_gnt} !== {ignt_pat[k], !ignt_pat[k]}) begin
        n_fail++;
        $display("FAIL drop_gnt k=%0d: got %b%b want %b%b", k, bus.i_gnt, bus.d_gnt, ignt_pat[k], !ignt_pat[k]);
      end
      step_post();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step_pre(); step_post();
    end
  endtask

  task automatic test_random();
    bit          p_i, p_d, p_we;
    logic [11:0] ia, da;
    logic [31:0] dd;
    p_i = 0; p_d = 0; p_we = 0; ia = 0; da = 0; dd = 0;
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!p_i && $urandom_range(0, 2) != 0) begin
        p_i = 1; ia = 12'($urandom_range(0, 15));
      end
      if (!p_d && $urandom_range(0, 2) != 0) begin
        p_d = 1; p_we = $urandom_range(0, 1) == 1; da = 12'($urandom_range(0, 15)); dd = $urandom;
      end
      drive(p_i, ia, p_d, p_we, da, dd);
      step_pre();
      n_checks++;
      if ({bus.i_gnt, bus.d_gnt, bus.mem_cen, bus.mem_wen, bus.mem_addr, bus.mem_din}
          !== {e_i_gnt, e_d_gnt, e_cen, e_wen, e_addr, e_din}) begin
        n_fail++;
        $display("FAIL rnd_bus k=%0d: got gnt=%b%b cen=%b wen=%b addr=%h din=%h want gnt=%b%b cen=%b wen=%b addr=%h din=%h",
                 k, bus.i_gnt, bus.d_gnt, bus.mem_cen, bus.mem_wen, bus.mem_addr, bus.mem_din,
                 e_i_gnt, e_d_gnt, e_cen, e_wen, e_addr, e_din);
      end
      n_checks++;
      if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata} !== {e_i_rv, e_d_rv, e_i_rd, e_d_rd}) begin
        n_fail++;
        $display("FAIL rnd_ret k=%0d: got rv=%b%b i=%h d=%h want rv=%b%b i=%h d=%h", k,
                 bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata, e_i_rv, e_d_rv, e_i_rd, e_d_rd);
      end
      if (e_i_gnt) p_i = 0;
      if (e_d_gnt) p_d = 0;
      step_post();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) ref_mem[a] = init_word(12'(a));
    m_pri_i = 1'b0; m_denied = 0; m_cyc = 0; m_last_i = '0; m_last_d = '0;
    test_reset();
    test_lone_ifetch();
    test_write_read();
    test_starve();
    test_alternating();
    test_mid_reset();
    test_starve_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
